// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse host controller.
// The optional error counter is enabled with PS2_MOUSE_ERR_CNT_EN.
package ps2_mouse_pkg;

    typedef enum logic [2:0] {
        INHIBIT  = 3'd0,
        REQ      = 3'd1,
        TX       = 3'd2,
        WAIT_ACK = 3'd3,
        STREAM   = 3'd4,
        ERR      = 3'd5
    } state_t;

    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam int         FRAME_BITS = 11;

    localparam int B0_BTN_MSB = 2;
    localparam int B0_SYNC    = 3;
    localparam int B0_XSIGN   = 4;
    localparam int B0_YSIGN   = 5;
    localparam int B0_XOVF    = 6;
    localparam int B0_YOVF    = 7;

    // Frame layout is {stop, parity, data[7:0], start}; parity is odd over data+parity.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return (f[0] == 1'b0) && (f[FRAME_BITS-1] == 1'b1) && (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_bit_cnt.sv
// Frame bit counter: counts PS/2 clock falls, cleared by the controller.
module ps2_bit_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       fall_i,
    input  logic       bit_reset_i,
    output logic [3:0] cnt_o
);

    logic [3:0] cnt_q;

    // Clear has priority over increment
    always_ff @(posedge clk) begin
        if (reset || bit_reset_i) begin
            cnt_q <= 4'd0;
        end else if (fall_i) begin
            cnt_q <= cnt_q + 4'd1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ps2_edge_sync.sv
// Pad synchroniser for the PS/2 clock and data lines with falling-edge detect on clock.
module ps2_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic data_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;

    // Synchroniser chains reset to the idle-high bus level
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign data_s_o = data_sync_q[SYNC_STAGES-1];
    assign fall_o   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse host: sends Enable Data Reporting, waits for ACK, assembles 3-byte packets.
// Defining PS2_MOUSE_ERR_CNT_EN adds a saturating err_count output.
module ps2_mouse_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int INHIBIT_CYC = 2500,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       init_done,
    output logic       pkt_valid,
    output logic [2:0] pkt_btn,
    output logic [8:0] pkt_dx,
    output logic [8:0] pkt_dy,
    output logic [1:0] pkt_ovf,
    output logic       frame_err
`ifdef PS2_MOUSE_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int TMAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    logic          data_s, fall_s, bit_reset_s;
    logic [3:0]    bit_cnt_s;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [6:0]    hdr_q, hdr_d;      // byte0 without its always-one sync bit
    logic [7:0]    byte1_q, byte1_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          init_done_q, init_done_d, pkt_valid_q, pkt_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [2:0]    pkt_btn_q, pkt_btn_d;
    logic [8:0]    pkt_dx_q, pkt_dx_d, pkt_dy_q, pkt_dy_d;
    logic [1:0]    pkt_ovf_q, pkt_ovf_d;

    logic [10:0] frame_s;
    logic [7:0]  rx_byte_s;
    logic        in_frame_s, frame_done_s, frame_good_s, counting_s, timeout_s, inhibit_done_s;

    ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .data_s_o   (data_s),
        .fall_o     (fall_s)
    );

    ps2_bit_cnt u_bit_cnt (
        .clk         (clk),
        .reset       (reset),
        .fall_i      (fall_s),
        .bit_reset_i (bit_reset_s),
        .cnt_o       (bit_cnt_s)
    );

    assign in_frame_s     = (state_q == TX) || (state_q == WAIT_ACK) || (state_q == STREAM);
    assign frame_s        = {data_s, rx_sh_q};
    assign rx_byte_s      = frame_s[8:1];
    assign frame_good_s   = frame_ok(frame_s);
    assign frame_done_s   = in_frame_s && fall_s && (bit_cnt_s == 4'(FRAME_BITS - 1));
    assign counting_s     = (state_q == INHIBIT) ? clk_oe_q :
                            (state_q == TX)      ? 1'b1 :
                            in_frame_s           ? (bit_cnt_s != 4'd0) : 1'b0;
    assign timeout_s      = in_frame_s && counting_s && (timer_q == TW'(TIMEOUT_CYC - 1));
    assign inhibit_done_s = (state_q == INHIBIT) && clk_oe_q && (timer_q == TW'(INHIBIT_CYC - 1));
    assign bit_reset_s    = !in_frame_s || (state_d != state_q) || frame_done_s || timeout_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INHIBIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            INHIBIT:  state_d = inhibit_done_s ? REQ : INHIBIT;
            REQ:      state_d = TX;
            TX: begin
                if (timeout_s)         state_d = ERR;
                else if (frame_done_s) state_d = data_s ? ERR : WAIT_ACK;
                else                   state_d = TX;
            end
            WAIT_ACK: begin
                if (timeout_s)         state_d = ERR;
                else if (frame_done_s) state_d = (frame_good_s && rx_byte_s == RSP_ACK) ? STREAM : ERR;
                else                   state_d = WAIT_ACK;
            end
            STREAM:   state_d = STREAM;
            ERR:      state_d = INHIBIT;
            default:  state_d = ERR;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        timer_d     = (state_d != state_q || !counting_s || (in_frame_s && fall_s) || timeout_s)
                      ? '0 : timer_q + TW'(1);
        rx_sh_d     = (in_frame_s && fall_s) ? frame_s[10:1] : rx_sh_q;
        tx_sh_d     = tx_sh_q;
        byte_idx_d  = byte_idx_q;
        hdr_d       = hdr_q;
        byte1_d     = byte1_q;
        pkt_btn_d   = pkt_btn_q;
        pkt_dx_d    = pkt_dx_q;
        pkt_dy_d    = pkt_dy_q;
        pkt_ovf_d   = pkt_ovf_q;
        pkt_valid_d = 1'b0;
        clk_oe_d    = (state_d == INHIBIT);
        init_done_d = (state_d == STREAM);
        frame_err_d = (state_q == ERR) ||
                      ((state_q == STREAM) && ((frame_done_s && !frame_good_s) || timeout_s));

        if (state_q == REQ) begin
            tx_sh_d = {1'b1, ~^CMD_ENABLE, CMD_ENABLE};
        end else if (state_q == TX && fall_s) begin
            tx_sh_d = {1'b1, tx_sh_q[9:1]};
        end else begin
            tx_sh_d = tx_sh_q;
        end

        // Start bit is held from REQ until the first device clock fall
        if (state_d == REQ) begin
            data_oe_d = 1'b1;
        end else if (state_d == TX) begin
            data_oe_d = (state_q == TX && fall_s && bit_cnt_s <= 4'd9) ? ~tx_sh_q[0] : data_oe_q;
        end else begin
            data_oe_d = 1'b0;
        end

        if (state_q != STREAM || timeout_s || (frame_done_s && !frame_good_s)) begin
            byte_idx_d = 2'd0;
        end else if (frame_done_s) begin
            case (byte_idx_q)
                2'd0: begin
                    if (rx_byte_s[B0_SYNC]) begin
                        hdr_d      = {rx_byte_s[7:4], rx_byte_s[2:0]};
                        byte_idx_d = 2'd1;
                    end else begin
                        byte_idx_d = 2'd0;
                    end
                end
                2'd1: begin
                    byte1_d    = rx_byte_s;
                    byte_idx_d = 2'd2;
                end
                2'd2: begin
                    pkt_btn_d   = hdr_q[B0_BTN_MSB:0];
                    pkt_dx_d    = {hdr_q[B0_XSIGN-1], byte1_q};
                    pkt_dy_d    = {hdr_q[B0_YSIGN-1], rx_byte_s};
                    pkt_ovf_d   = {hdr_q[B0_YOVF-1], hdr_q[B0_XOVF-1]};
                    pkt_valid_d = 1'b1;
                    byte_idx_d  = 2'd0;
                end
                default: byte_idx_d = 2'd0;
            endcase
        end else begin
            byte_idx_d = byte_idx_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q     <= '0;
            rx_sh_q     <= 10'd0;
            tx_sh_q     <= 10'd0;
            byte_idx_q  <= 2'd0;
            hdr_q       <= 7'd0;
            byte1_q     <= 8'd0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            init_done_q <= 1'b0;
            pkt_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            pkt_btn_q   <= 3'd0;
            pkt_dx_q    <= 9'd0;
            pkt_dy_q    <= 9'd0;
            pkt_ovf_q   <= 2'd0;
        end else begin
            timer_q     <= timer_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            byte_idx_q  <= byte_idx_d;
            hdr_q       <= hdr_d;
            byte1_q     <= byte1_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            init_done_q <= init_done_d;
            pkt_valid_q <= pkt_valid_d;
            frame_err_q <= frame_err_d;
            pkt_btn_q   <= pkt_btn_d;
            pkt_dx_q    <= pkt_dx_d;
            pkt_dy_q    <= pkt_dy_d;
            pkt_ovf_q   <= pkt_ovf_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign init_done   = init_done_q;
    assign pkt_valid   = pkt_valid_q;
    assign pkt_btn     = pkt_btn_q;
    assign pkt_dx      = pkt_dx_q;
    assign pkt_dy      = pkt_dy_q;
    assign pkt_ovf     = pkt_ovf_q;
    assign frame_err   = frame_err_q;

`ifdef PS2_MOUSE_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else if (frame_err_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end else begin
            err_cnt_q <= err_cnt_q;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl with a behavioural open-drain PS/2 mouse model.
module tb_ps2_mouse_ctrl;
    import ps2_mouse_pkg::*;

    localparam int H = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_oe, ps2_data_oe, init_done, pkt_valid, frame_err;
    logic [2:0] pkt_btn;
    logic [8:0] pkt_dx, pkt_dy;
    logic [1:0] pkt_ovf;
`ifdef PS2_MOUSE_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int tests = 0;
    int fails = 0;
    int pkt_cnt = 0;
    int ferr_cnt = 0;

    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    ps2_mouse_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .init_done   (init_done),
        .pkt_valid   (pkt_valid),
        .pkt_btn     (pkt_btn),
        .pkt_dx      (pkt_dx),
        .pkt_dy      (pkt_dy),
        .pkt_ovf     (pkt_ovf),
        .frame_err   (frame_err)
`ifdef PS2_MOUSE_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_valid) pkt_cnt++;
        if (frame_err) ferr_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic dev_send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            dev_data = bits[i];
            cyc(H);
            dev_clk = 1'b0;
            cyc(H);
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        dev_send_bits(mk_frame(b, bad), 11);
        cyc(3 * H);
    endtask

    // Device side of a host-to-device transfer; clock is left low after a partial transfer
    task automatic dev_host_rx(input int nfalls, output logic [10:0] bits, output int oe_len, output bit ok);
        int n;
        ok = 1'b1; bits = 11'd0; oe_len = 0; n = 0;
        while (!ps2_clk_oe && n < 10000) begin cyc(1); n++; end
        if (!ps2_clk_oe) begin ok = 1'b0; return; end
        while (ps2_clk_oe && oe_len < 10000) begin oe_len++; cyc(1); end
        if (ps2_clk_oe) begin ok = 1'b0; return; end
        cyc(4);
        bits[0] = ps2_data_i;
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11) dev_data = 1'b0;
            cyc(H);
            dev_clk = 1'b0;
            cyc(H);
            if (k <= 10) bits[k] = ps2_data_i;
            if (!(k == nfalls && nfalls < 11)) dev_clk = 1'b1;
            if (k == 11) dev_data = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        tests++;
        if ({ps2_clk_oe, ps2_data_oe, init_done, pkt_valid, pkt_btn, pkt_dx, pkt_dy, pkt_ovf, frame_err} !== 28'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", {ps2_clk_oe, ps2_data_oe, init_done, pkt_valid, pkt_btn, pkt_dx, pkt_dy, pkt_ovf, frame_err});
        end
        tests++;
        if (dut.state_q !== INHIBIT || dut.bit_cnt_s !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: state %0d bitcnt %0d want %0d/0", dut.state_q, dut.bit_cnt_s, INHIBIT);
        end
        reset = 1'b0;
    endtask

    task automatic test_init(input string tag);
        logic [10:0] bits;
        int          oe_len;
        bit          ok;
        dev_host_rx(11, bits, oe_len, ok);
        tests++;
        if (!ok || oe_len !== 2500) begin
            fails++;
            $display("FAIL %s inhibit_len: got %0d ok=%0d want 2500", tag, oe_len, ok);
        end
        tests++;
        if (bits !== 11'h5E8) begin
            fails++;
            $display("FAIL %s host_bits: got %h want 5e8", tag, bits);
        end
        cyc(2 * H);
        tests++;
        if (init_done !== 1'b0) begin
            fails++;
            $display("FAIL %s init_before_ack: got %b want 0", tag, init_done);
        end
        send_byte(RSP_ACK, 1'b0);
        tests++;
        if (init_done !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            fails++;
            $display("FAIL %s init_done: got %b oe %b%b want 1 oe 00", tag, init_done, ps2_clk_oe, ps2_data_oe);
        end
    endtask

    task automatic test_packet();
        int p0 = pkt_cnt;
        int f0 = ferr_cnt;
        send_byte(8'h09, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hFE, 1'b0);
        tests++;
        if (pkt_cnt !== p0 + 1 || ferr_cnt !== f0) begin
            fails++;
            $display("FAIL packet_count: got pkts %0d errs %0d want 1/0", pkt_cnt - p0, ferr_cnt - f0);
        end
        tests++;
        if ({pkt_btn, pkt_dx, pkt_dy, pkt_ovf} !== {3'b001, 9'h005, 9'h0FE, 2'b00}) begin
            fails++;
            $display("FAIL packet_fields: got btn %b dx %h dy %h ovf %b want 001/005/0fe/00", pkt_btn, pkt_dx, pkt_dy, pkt_ovf);
        end
    endtask

    task automatic test_parity_err();
        int p0 = pkt_cnt;
        int f0 = ferr_cnt;
        send_byte(8'h08, 1'b0);
        send_byte(8'h33, 1'b1);
        tests++;
        if (ferr_cnt !== f0 + 1 || pkt_cnt !== p0) begin
            fails++;
            $display("FAIL parity_err: got errs %0d pkts %0d want 1/0", ferr_cnt - f0, pkt_cnt - p0);
        end
        send_byte(8'h29, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'hF0, 1'b0);
        tests++;
        if (pkt_cnt !== p0 + 1 || ferr_cnt !== f0 + 1) begin
            fails++;
            $display("FAIL parity_recover_count: got pkts %0d errs %0d want 1/1", pkt_cnt - p0, ferr_cnt - f0);
        end
        tests++;
        if ({pkt_btn, pkt_dx, pkt_dy, pkt_ovf} !== {3'b001, 9'h010, 9'h1F0, 2'b00}) begin
            fails++;
            $display("FAIL parity_recover_fields: got btn %b dx %h dy %h ovf %b want 001/010/1f0/00", pkt_btn, pkt_dx, pkt_dy, pkt_ovf);
        end
    endtask

    task automatic test_timeout();
        int p0 = pkt_cnt;
        int f0 = ferr_cnt;
        int n = 0;
        dev_send_bits(mk_frame(8'h55, 1'b0), 5);
        while (ferr_cnt == f0 && n < 60000) begin cyc(1); n++; end
        tests++;
        if (n + H < 49900 || n + H > 50100) begin
            fails++;
            $display("FAIL timeout_delay: got %0d cycles want about 50000", n + H);
        end
        cyc(5);
        tests++;
        if (ferr_cnt !== f0 + 1 || dut.bit_cnt_s !== 4'd0 || pkt_cnt !== p0) begin
            fails++;
            $display("FAIL timeout_state: errs %0d bitcnt %0d pkts %0d want 1/0/0", ferr_cnt - f0, dut.bit_cnt_s, pkt_cnt - p0);
        end
        send_byte(8'h0A, 1'b0);
        send_byte(8'h7F, 1'b0);
        send_byte(8'h80, 1'b0);
        tests++;
        if (pkt_cnt !== p0 + 1 || {pkt_btn, pkt_dx, pkt_dy, pkt_ovf} !== {3'b010, 9'h07F, 9'h080, 2'b00}) begin
            fails++;
            $display("FAIL timeout_recover: pkts %0d btn %b dx %h dy %h ovf %b want 1 010/07f/080/00", pkt_cnt - p0, pkt_btn, pkt_dx, pkt_dy, pkt_ovf);
        end
    endtask

    task automatic test_resync();
        int p0 = pkt_cnt;
        int f0 = ferr_cnt;
        send_byte(8'h00, 1'b0);
        tests++;
        if (dut.byte_idx_q !== 2'd0) begin
            fails++;
            $display("FAIL resync_drop: byte_idx %0d want 0", dut.byte_idx_q);
        end
        send_byte(8'h08, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        tests++;
        if (pkt_cnt !== p0 + 1 || ferr_cnt !== f0 ||
            {pkt_btn, pkt_dx, pkt_dy, pkt_ovf} !== {3'b000, 9'h001, 9'h002, 2'b00}) begin
            fails++;
            $display("FAIL resync_packet: pkts %0d errs %0d btn %b dx %h dy %h ovf %b want 1/0 000/001/002/00",
                     pkt_cnt - p0, ferr_cnt - f0, pkt_btn, pkt_dx, pkt_dy, pkt_ovf);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [10:0] bits;
        int          oe_len;
        bit          ok;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        dev_host_rx(4, bits, oe_len, ok);
        cyc(5);
        tests++;
        if (!ok || dut.state_q !== TX || ps2_data_oe !== 1'b1) begin
            fails++;
            $display("FAIL midtx_pre: ok %0d state %0d data_oe %b want 1/%0d/1", ok, dut.state_q, ps2_data_oe, TX);
        end
        reset = 1'b1;
        cyc(1);
        tests++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || dut.state_q !== INHIBIT || init_done !== 1'b0) begin
            fails++;
            $display("FAIL midtx_reset: oe %b%b state %0d init %b want 00/%0d/0", ps2_clk_oe, ps2_data_oe, dut.state_q, init_done, INHIBIT);
        end
        cyc(1);
        reset = 1'b0;
        dev_clk = 1'b1;
        test_init("reinit");
    endtask

    initial begin
        test_reset();
        test_init("init");
        test_packet();
        test_parity_err();
        test_timeout();
        test_resync();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_ctrl.md
Name: ps2_mouse_ctrl

Overview:
PS/2 mouse host controller. It initialises the mouse by sending 0xF4 (Enable Data Reporting), checks for the 0xFA acknowledge, then receives stream-mode frames and assembles 3-byte movement packets. It sequences the frame bit counter using PS/2 clock falling edges, validates start, parity and stop bits, and applies a mid-frame timeout. It sits between the open-drain PS/2 pad logic and the game input logic.

Parameters:
SYNC_STAGES, 2, synchroniser depth for ps2_clk_i/ps2_data_i
INHIBIT_CYC, 2500, clk cycles ps2_clk is held low before a host transmit (100 us @ 25 MHz)
TIMEOUT_CYC, 50000, max clk cycles between PS/2 falling edges inside a frame (2 ms @ 25 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_clk_i  in  1  raw PS/2 clock pad input
ps2_data_i  in  1  raw PS/2 data pad input
ps2_clk_oe  out  1  1 = drive PS/2 clock low
ps2_data_oe  out  1  1 = drive PS/2 data low
init_done  out  1  high once 0xFA has been received; low again on any restart
pkt_valid  out  1  one-cycle pulse when a full packet is available
pkt_btn  out  3  {M,R,L} from byte0[2:0]
pkt_dx  out  9  {byte0[4], byte1}, two's complement
pkt_dy  out  9  {byte0[5], byte2}, two's complement
pkt_ovf  out  2  {byte0[7] Y, byte0[6] X}
frame_err  out  1  one-cycle pulse on a parity, start, stop, ack or timeout error

Behaviour:
- Clocking: clock clk; reset is synchronous, active-high. Pad inputs pass through SYNC_STAGES flops. fall = synced clk previous 1, current 0.
- Reset values: all outputs 0; state INHIBIT; bit_cnt 0; byte_idx 0; timers 0.
- Bit counter: 4-bit, cleared by reset or by a controller bit_reset, incremented on fall. bit_reset is asserted on every frame completion, error and state change.
- INHIBIT: clk_oe=1 for INHIBIT_CYC cycles, then go to REQ.
- REQ: one cycle with data_oe=1 (start bit) and clk_oe=0; then go to TX with shift reg = 0xF4 and parity = ~^0xF4.
- TX, transmit bits after each fall:
  - falls 1..8: data_oe = ~data[fall-1], LSB first.
  - fall 9: parity bit.
  - fall 10: data_oe=0 (stop).
  - fall 11: sample data; 0 → WAIT_ACK, 1 → ERR.
- RX frame, used by WAIT_ACK and STREAM:
  - Sample data on each fall into an 11-bit shift reg.
  - On the 11th fall, valid iff start=0, stop=1 and odd parity over data+parity.
  - Invalid → frame_err pulse and frame discarded.
- WAIT_ACK: valid byte 0xFA → STREAM and init_done=1. Any other byte or error → ERR.
- STREAM, per valid byte:
  - byte_idx 0: accept only if bit3=1, else drop and stay at idx 0 (resync, no frame_err).
  - idx 1 and 2: store.
  - After idx 2: register outputs, pkt_valid=1 for one cycle (latency 1 clk after the 11th fall), idx→0.
  - Frame error in STREAM: idx→0, remain in STREAM.
- Timeout: a timer counts while bit_cnt≠0 and clears on fall. Reaching TIMEOUT_CYC → frame_err and bit_reset.
  - In TX or WAIT_ACK: → ERR.
  - In STREAM: idx→0.
  - TX also times out if no fall within TIMEOUT_CYC of leaving REQ.
- ERR: frame_err pulse, init_done=0, → INHIBIT (retry forever).
- Outputs pkt_* hold their last value between pulses.
- oe outputs only in INHIBIT/REQ/TX; released (0) in all other states.
- Reset mid-operation: oe released the same cycle after the reset edge; restart from INHIBIT.

Optional Feature:
- Macro: PS2_MOUSE_ERR_CNT_EN.
- With it defined: extra output err_count[7:0]. It increments on every frame_err pulse, saturates at 255, and clears only on reset.
- Without it: the port and counter do not exist, and the rest of the behaviour is identical.

Decomposition:
- Package ps2_mouse_pkg:
  - State enum (INHIBIT, REQ, TX, WAIT_ACK, STREAM, ERR).
  - Constants CMD_ENABLE=8'hF4, RSP_ACK=8'hFA, FRAME_BITS=11.
  - Byte0 bit index constants.
- Sub-module ps2_edge_sync: synchroniser plus falling-edge detect, outputs data_s and fall.
- The bit counter stays a separate existing instance driven by fall and bit_reset.

Test Plan:
- Init: release reset, model answers 0xF4 with ack bit 0 then frame 0xFA → clk_oe low 2500 cycles, host bits 0,0,1,0,1,1,1,1, parity 0; init_done=1.
- Packet: bytes 0x09,0x05,0xFE → pkt_valid one pulse, btn=3'b001, dx=9'h005, dy=9'h0FE (positive), ovf=0.
- Parity error: byte with a wrong parity bit in STREAM → frame_err pulse, no pkt_valid; next good 3 bytes produce a packet.
- Timeout: stop the clock after 5 bits, wait 50000 cycles → frame_err, bit_cnt 0; the following full packet is received correctly.
- Resync: stream 0x00,0x08,0x01,0x02 → first byte dropped; packet btn=0, dx=1, dy=2.
- Reset during TX fall 4 → oe both 0 next cycle, state INHIBIT; re-init completes.
